// File: rtl/amax10_sysid_pkg.sv
`default_nettype none
// ============================================================================
// Module  : amax10_sysid_pkg
// Purpose : Shared types and constants for the system-ID checker.
//           - sysid_state_e : checker FSM states
//           - ADDR_ID/ADDR_TS : Avalon word addresses of the sysid slave
//           - TO_CNT_W : width of the per-read stall counter
// Revision: 1.0 - initial release
// ============================================================================
package amax10_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } sysid_state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int TO_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/amax10_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module  : amax10_sysid_checker
// Purpose : Avalon-MM read master that reads the system-ID slave (word 0 =
//           ID, word 1 = build timestamp), compares both words against the
//           expected values and reports pass/fail/timeout.
// Ports   : clock, reset_n      - clock, asynchronous active-low reset
//           start               - one-cycle request, ignored while busy
//           avm_*               - Avalon-MM read master to the sysid slave
//           busy, done          - check in progress / one-cycle end pulse
//           id_ok, ts_ok        - sticky compare results
//           timeout             - sticky: a read stalled too long
//           id_value, ts_value  - captured words
// Revision: 1.0 - initial release
// ============================================================================
module amax10_sysid_checker
  import amax10_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h555B_0721,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // Counter value at which the TIMEOUT_CYCLES-th stall cycle is being seen.
  localparam logic [TO_CNT_W-1:0] TIMEOUT_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  sysid_state_e          state;
  logic [TO_CNT_W-1:0]   wait_cnt;

  // Bus strobes and status are decoded straight from the state register so
  // they are glitch-free and collapse immediately on an asynchronous reset.
  assign avm_read    = (state == RD_ID) || (state == RD_TS);
  assign avm_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RD_ID;
            wait_cnt <= '0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
          end
        end

        RD_ID: begin
          if (!avm_waitrequest) begin
            id_value <= avm_readdata;
            wait_cnt <= '0;
            state    <= RD_TS;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            timeout <= 1'b1;
            state   <= FINISH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RD_TS: begin
          if (!avm_waitrequest) begin
            // Compare on entry to FINISH so the flags are valid together
            // with the done pulse; the timestamp is taken from the bus.
            ts_value <= avm_readdata;
            id_ok    <= (id_value == EXPECTED_ID);
            ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            state    <= FINISH;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            // id_ok/ts_ok were cleared at start and stay 0 on a timeout.
            timeout <= 1'b1;
            state   <= FINISH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amax10_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_amax10_sysid_checker
// Purpose : Self-checking bench for amax10_sysid_checker. A simple sysid
//           slave is emulated cycle by cycle; expected behaviour comes from a
//           table of directed vectors and a phase-length reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_amax10_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h555B_0721;
  localparam int          TOUT   = 4;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int tests;
  int fails;

  amax10_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TOUT)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One vector: slave words, stall cycles per read, start spam, expectations.
  typedef struct {
    logic [31:0] idw;
    logic [31:0] tsw;
    int          sid;
    int          sts;
    bit          spam;
    bit          e_idok;
    bit          e_tsok;
    bit          e_to;
    int          e_done;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a read stalled for TOUT or more cycles times out after
  // TOUT read cycles; otherwise each read lasts stall+1 cycles.
  function automatic vec_t model(input logic [31:0] idw, input logic [31:0] tsw,
                                 input int sid, input int sts, input bit spam);
    vec_t v;
    v.idw    = idw;
    v.tsw    = tsw;
    v.sid    = sid;
    v.sts    = sts;
    v.spam   = spam;
    v.e_to   = (sid >= TOUT) || (sts >= TOUT);
    v.e_idok = !v.e_to && (idw == EXP_ID);
    v.e_tsok = !v.e_to && (tsw == EXP_TS);
    if (sid >= TOUT)      v.e_done = TOUT + 1;
    else if (sts >= TOUT) v.e_done = sid + 1 + TOUT + 1;
    else                  v.e_done = sid + sts + 3;
    return v;
  endfunction

  // Runs one check starting at a negedge; cycle k is the k-th cycle after
  // the edge that samples start.
  task automatic run_vec(input vec_t v, input string nm);
    int          n_id, n_ts, j;
    logic [31:0] e_idv, e_tsv;
    bit          er, ea, eb, ed;
    n_id  = (v.sid >= TOUT) ? TOUT : v.sid + 1;
    n_ts  = (v.sid >= TOUT) ? 0 : ((v.sts >= TOUT) ? TOUT : v.sts + 1);
    e_idv = (v.sid >= TOUT) ? 32'h0 : v.idw;
    e_tsv = (v.sid < TOUT && v.sts < TOUT) ? v.tsw : 32'h0;

    start           = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata    = $urandom;
    @(negedge clock);
    for (int k = 1; k <= v.e_done + 1; k++) begin
      er = (k <= n_id + n_ts);
      ea = (k > n_id) && (k <= n_id + n_ts);
      eb = (k <= v.e_done);
      ed = (k == v.e_done);
      chk($sformatf("%s c%0d {read,addr,busy,done}", nm, k),
          {60'd0, avm_read, avm_address, busy, done}, {60'd0, er, ea, eb, ed});
      if (k >= v.e_done) begin
        chk($sformatf("%s c%0d {id_ok,ts_ok,timeout}", nm, k),
            {61'd0, id_ok, ts_ok, timeout}, {61'd0, v.e_idok, v.e_tsok, v.e_to});
        chk($sformatf("%s c%0d {id_value,ts_value}", nm, k),
            {id_value, ts_value}, {e_idv, e_tsv});
      end
      // Slave response for the edge closing cycle k.
      if (k <= n_id) begin
        avm_waitrequest = (k <= v.sid);
        avm_readdata    = avm_waitrequest ? $urandom : v.idw;
      end else if (k <= n_id + n_ts) begin
        j               = k - n_id;
        avm_waitrequest = (j <= v.sts);
        avm_readdata    = avm_waitrequest ? $urandom : v.tsw;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = $urandom;
      end
      start = (k <= v.e_done) ? (v.spam ? 1'($urandom_range(0, 1)) : 1'b0) : 1'b0;
      @(negedge clock);
    end
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    tests = 0;
    fails = 0;

    //              idw           tsw           sid sts spam idok tsok to  done
    tbl[0] = '{32'h0000_0000, 32'h555B_0721, 0,  0,  1'b0, 1'b1, 1'b1, 1'b0, 3};
    tbl[1] = '{32'h0000_0000, 32'h555B_0722, 0,  0,  1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[2] = '{32'h0000_0000, 32'h555B_0721, 3,  3,  1'b0, 1'b1, 1'b1, 1'b0, 9};
    tbl[3] = '{32'h0000_0000, 32'h555B_0721, 99, 0,  1'b0, 1'b0, 1'b0, 1'b1, 5};
    tbl[4] = '{32'h0000_0000, 32'h555B_0721, 1,  99, 1'b0, 1'b0, 1'b0, 1'b1, 7};
    tbl[5] = '{32'h1234_5678, 32'h555B_0721, 2,  0,  1'b0, 1'b0, 1'b1, 1'b0, 5};
    tbl[6] = '{32'h0000_0000, 32'h555B_0721, 1,  1,  1'b1, 1'b1, 1'b1, 1'b0, 5};
    tbl[7] = '{32'h0000_0000, 32'h555B_0721, 3,  4,  1'b1, 1'b0, 1'b0, 1'b1, 9};

    reset_n         = 1'b0;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'h0;
    #1;
    chk("reset outputs", {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout,
                          id_value, ts_value}, '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Extra start pulses during a check, then reset while in RD_TS.
    start        = 1'b1;
    avm_readdata = 32'hDEAD_BEEF;
    @(negedge clock);                        // cycle 1: RD_ID, capture next
    chk("rst-seq rd_id", {62'd0, avm_read, avm_address}, {62'd0, 1'b1, 1'b0});
    start           = 1'b1;
    avm_waitrequest = 1'b0;
    @(negedge clock);                        // cycle 2: RD_TS
    chk("rst-seq rd_ts", {62'd0, avm_read, avm_address}, {62'd0, 1'b1, 1'b1});
    chk("rst-seq id captured", {32'd0, id_value}, {32'd0, 32'hDEAD_BEEF});
    avm_waitrequest = 1'b1;
    @(negedge clock);                        // still stalled in RD_TS
    chk("rst-seq stalled addr", {62'd0, avm_read, avm_address}, {62'd0, 1'b1, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst-seq async drop", {avm_read, busy, done, id_ok, ts_ok, timeout,
                               id_value, ts_value}, '0);
    @(negedge clock);                        // start=1 across an edge in reset
    chk("rst-seq reset wins", {62'd0, busy, avm_read}, '0);
    reset_n         = 1'b1;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clock);
    chk("rst-seq idle after release", {62'd0, busy, done}, '0);
    run_vec(tbl[0], "after-reset");

    // Randomised checks against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] idw, tsw;
      idw = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom;
      tsw = ($urandom_range(0, 2) != 0) ? EXP_TS : (EXP_TS ^ (32'h1 << $urandom_range(0, 31)));
      rv  = model(idw, tsw, $urandom_range(0, 5), $urandom_range(0, 5),
                  1'($urandom_range(0, 1)));
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
